// File: rtl/divider_ctrl.sv
// Divider sequencer: changes the ratio only while the divider is powered down,
// then waits for the fed-back divided clock to settle before reporting lock.
module divider_ctrl #(
    parameter int unsigned PD_SETUP_CYC = 2,
    parameter int unsigned PD_HOLD_CYC  = 2,
    parameter int unsigned SETTLE_EDGES = 4,
    parameter int unsigned TIMEOUT_CYC  = 4096,
    parameter logic [7:0]  RESET_DIV    = 8'd2
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       pd_req,
    input  logic       req_valid,
    input  logic [7:0] req_div,
    output logic       req_ready,
    output logic       div_power_down,
    output logic [7:0] div_divide_by,
    input  logic       div_clk_fb,
    output logic       locked,
    output logic       done,
    output logic       err
);

    localparam int unsigned PhaseMax =
        (PD_SETUP_CYC > PD_HOLD_CYC) ? PD_SETUP_CYC : PD_HOLD_CYC;
    localparam int unsigned PhaseW = (PhaseMax > 1) ? $clog2(PhaseMax) : 1;
    localparam int unsigned EdgeW  = (SETTLE_EDGES > 1) ? $clog2(SETTLE_EDGES) : 1;
    localparam int unsigned TmoW   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    // Counters only ever reach these terminal values, so they never wrap.
    localparam logic [PhaseW-1:0] SetupLast = PhaseW'(PD_SETUP_CYC - 1);
    localparam logic [PhaseW-1:0] HoldLast  = PhaseW'(PD_HOLD_CYC - 1);
    localparam logic [EdgeW-1:0]  EdgeLast  = EdgeW'(SETTLE_EDGES - 1);
    localparam logic [TmoW-1:0]   TmoLast   = TmoW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        StOff,
        StPdSetup,
        StLoad,
        StPdHold,
        StSettle,
        StIdle
    } state_e;

    state_e            state_q, state_d;
    logic [PhaseW-1:0] phase_q, phase_d;
    logic [EdgeW-1:0]  edge_cnt_q, edge_cnt_d;
    logic [TmoW-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [7:0]        div_q, div_d;
    logic [7:0]        pend_q, pend_d;
    logic              locked_q, locked_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              fb_sync1_q, fb_sync2_q, fb_prev_q;
    logic              fb_rise;
    logic              accept;

    assign fb_rise = fb_sync2_q & ~fb_prev_q;
    assign accept  = req_valid & req_ready;

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        edge_cnt_d = edge_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        div_d      = div_q;
        pend_d     = pend_q;
        locked_d   = locked_q;
        done_d     = 1'b0;
        err_d      = 1'b0;

        if (pd_req) begin
            // Abandon whatever is in flight; an unloaded ratio is dropped.
            state_d    = StOff;
            phase_d    = '0;
            edge_cnt_d = '0;
            tmo_cnt_d  = '0;
            pend_d     = div_q;
            locked_d   = 1'b0;
        end else begin
            unique case (state_q)
                StOff: begin
                    state_d = StPdHold;
                    phase_d = '0;
                end
                StPdSetup: begin
                    if (phase_q == SetupLast) begin
                        state_d = StLoad;
                        phase_d = '0;
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
                StLoad: begin
                    div_d   = pend_q;
                    state_d = StPdHold;
                    phase_d = '0;
                end
                StPdHold: begin
                    if (phase_q == HoldLast) begin
                        state_d    = StSettle;
                        phase_d    = '0;
                        edge_cnt_d = '0;
                        tmo_cnt_d  = '0;
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
                StSettle: begin
                    if (fb_rise && (edge_cnt_q == EdgeLast)) begin
                        done_d   = 1'b1;
                        locked_d = 1'b1;
                        state_d  = StIdle;
                    end else if (tmo_cnt_q == TmoLast) begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + 1'b1;
                        if (fb_rise) begin
                            edge_cnt_d = edge_cnt_q + 1'b1;
                        end
                    end
                end
                StIdle: begin
                    if (accept) begin
                        if (req_div < 8'd2) begin
                            err_d = 1'b1;
                        end else begin
                            pend_d   = req_div;
                            locked_d = 1'b0;
                            state_d  = StPdSetup;
                            phase_d  = '0;
                        end
                    end
                end
                default: begin
                    state_d = StOff;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StOff;
            phase_q    <= '0;
            edge_cnt_q <= '0;
            tmo_cnt_q  <= '0;
            div_q      <= RESET_DIV;
            pend_q     <= RESET_DIV;
            locked_q   <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            fb_sync1_q <= 1'b0;
            fb_sync2_q <= 1'b0;
            fb_prev_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            edge_cnt_q <= edge_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            div_q      <= div_d;
            pend_q     <= pend_d;
            locked_q   <= locked_d;
            done_q     <= done_d;
            err_q      <= err_d;
            fb_sync1_q <= div_clk_fb;
            fb_sync2_q <= fb_sync1_q;
            fb_prev_q  <= fb_sync2_q;
        end
    end

    assign req_ready      = (state_q == StIdle) && !pd_req;
    assign div_power_down = (state_q == StOff) || (state_q == StPdSetup) ||
                            (state_q == StLoad) || (state_q == StPdHold);
    assign div_divide_by  = div_q;
    assign locked         = locked_q;
    assign done           = done_q;
    assign err            = err_q;

endmodule

// File: tb/tb_divider_ctrl.sv
// Bench for divider_ctrl: countdown-based timeline model checked every cycle,
// plus directed sequences with hand-computed expectations.
module tb_divider_ctrl;

    localparam int PD_SETUP = 2;
    localparam int PD_HOLD  = 2;
    localparam int EDGES    = 4;
    localparam int TIMEOUT  = 4096;

    logic       clk_in = 1'b0;
    logic       rst_n;
    logic       pd_req;
    logic       req_valid;
    logic [7:0] req_div;
    logic       req_ready;
    logic       div_power_down;
    logic [7:0] div_divide_by;
    logic       div_clk_fb = 1'b0;
    logic       locked;
    logic       done;
    logic       err;

    int n_vec = 0;
    int n_bad = 0;
    bit fb_en = 1'b0;
    int fb_cnt = 0;

    divider_ctrl dut (
        .clk_in         (clk_in),
        .rst_n          (rst_n),
        .pd_req         (pd_req),
        .req_valid      (req_valid),
        .req_div        (req_div),
        .req_ready      (req_ready),
        .div_power_down (div_power_down),
        .div_divide_by  (div_divide_by),
        .div_clk_fb     (div_clk_fb),
        .locked         (locked),
        .done           (done),
        .err            (err)
    );

    always #5 clk_in = ~clk_in;

    // Feedback clock: toggles every 2 clk_in cycles while enabled, else low.
    initial begin
        forever begin
            @(posedge clk_in);
            #3;
            if (fb_en) begin
                fb_cnt++;
                if (fb_cnt >= 2) begin
                    div_clk_fb = ~div_clk_fb;
                    fb_cnt = 0;
                end
            end else begin
                div_clk_fb = 1'b0;
                fb_cnt = 0;
            end
        end
    end

    // Model: remaining powered-down cycles, countdown to the ratio load, and a
    // settle window counting feedback rises and elapsed cycles.
    bit         m_s1 = 0, m_s2 = 0, m_s3 = 0;
    bit         m_off = 1;
    int         m_pd_left = 0;
    int         m_load_in = -1;
    bit         m_settling = 0;
    int         m_edges = 0;
    int         m_scyc = 0;
    logic [7:0] m_div = 8'd2;
    logic [7:0] m_pend = 8'd2;
    bit         m_locked = 0, m_done = 0, m_err = 0;
    bit         m_rise, m_idle;

    initial begin
        forever begin
            @(posedge clk_in or negedge rst_n);
            if (!rst_n) begin
                m_s1 = 0; m_s2 = 0; m_s3 = 0;
                m_off = 1; m_pd_left = 0; m_load_in = -1; m_settling = 0;
                m_edges = 0; m_scyc = 0; m_div = 8'd2; m_locked = 0;
                m_done = 0; m_err = 0;
            end else begin
                m_rise = m_s2 && !m_s3;
                m_idle = !m_off && (m_pd_left == 0) && !m_settling;
                m_s3 = m_s2; m_s2 = m_s1; m_s1 = div_clk_fb;
                m_done = 0; m_err = 0;
                if (pd_req) begin
                    m_off = 1; m_pd_left = 0; m_load_in = -1; m_settling = 0;
                    m_locked = 0;
                end else if (m_off) begin
                    m_off = 0;
                    m_pd_left = PD_HOLD;
                end else if (m_pd_left > 0) begin
                    if (m_load_in > 0) begin
                        m_load_in--;
                        if (m_load_in == 0) begin
                            m_div = m_pend;
                            m_load_in = -1;
                        end
                    end
                    m_pd_left--;
                    if (m_pd_left == 0) begin
                        m_settling = 1; m_edges = 0; m_scyc = 0;
                    end
                end else if (m_settling) begin
                    if (m_rise) m_edges++;
                    if (m_edges == EDGES) begin
                        m_done = 1; m_locked = 1; m_settling = 0;
                    end else if (m_scyc == TIMEOUT - 1) begin
                        m_err = 1; m_settling = 0;
                    end else begin
                        m_scyc++;
                    end
                end else if (m_idle && req_valid) begin
                    if (req_div < 8'd2) begin
                        m_err = 1;
                    end else begin
                        m_pend = req_div;
                        m_locked = 0;
                        m_pd_left = PD_SETUP + 1 + PD_HOLD;
                        m_load_in = PD_SETUP + 1;
                    end
                end
            end
        end
    end

    logic [12:0] exp_v, act_v;

    initial begin
        forever begin
            @(negedge clk_in);
            exp_v = {(!m_off && (m_pd_left == 0) && !m_settling && !pd_req),
                     (m_off || (m_pd_left > 0)), m_div, m_locked, m_done, m_err};
            act_v = {req_ready, div_power_down, div_divide_by, locked, done, err};
            n_vec++;
            if (act_v !== exp_v) begin
                n_bad++;
                $display("FAIL cycle_compare t=%0t: {rdy,pd,div,lck,done,err} got %h, want %h",
                         $time, act_v, exp_v);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #3;
    endtask

    task automatic request(input logic [7:0] d);
        req_valid = 1'b1;
        req_div   = d;
        step();
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int limit);
        int n;
        n = 0;
        while (!done && n < limit) begin
            step();
            n++;
        end
        check(name, int'(done), 1);
    endtask

    initial begin
        int n;
        int dones;
        rst_n = 1'b1; pd_req = 1'b0; req_valid = 1'b0; req_div = 8'd0;
        #1 rst_n = 1'b0;
        #1;
        check("reset_pd", int'(div_power_down), 1);
        check("reset_div", int'(div_divide_by), 2);
        check("reset_ready", int'(req_ready), 0);
        check("reset_locked", int'(locked), 0);
        fb_en = 1'b1;
        repeat (3) step();
        rst_n = 1'b1;

        // Power-up: OFF -> PD_HOLD (2 cycles) -> SETTLE.
        step(); step();
        check("boot_pd_hold", int'(div_power_down), 1);
        step();
        check("boot_pd_low", int'(div_power_down), 0);
        wait_done("boot_done", 200);
        check("boot_locked", int'(locked), 1);
        check("boot_div", int'(div_divide_by), 2);
        step();

        // Ratio 8: pd one cycle later, ratio three cycles later, pd low two after.
        request(8'd8);
        check("r8_pd_after_accept", int'(div_power_down), 1);
        check("r8_unlocked", int'(locked), 0);
        step(); step();
        check("r8_div_before_load", int'(div_divide_by), 2);
        step();
        check("r8_div_at_3", int'(div_divide_by), 8);
        step();
        check("r8_pd_hold", int'(div_power_down), 1);
        step();
        check("r8_pd_low", int'(div_power_down), 0);
        wait_done("r8_done", 200);
        check("r8_locked", int'(locked), 1);
        step();

        // Illegal ratios.
        request(8'd1);
        check("r1_err", int'(err), 1);
        check("r1_div", int'(div_divide_by), 8);
        check("r1_locked", int'(locked), 1);
        step();
        check("r1_err_clear", int'(err), 0);
        request(8'd0);
        check("r0_err", int'(err), 1);
        check("r0_div", int'(div_divide_by), 8);
        step();

        // Timeout with the feedback held low.
        fb_en = 1'b0;
        step(); step();
        request(8'd16);
        n = 0;
        while (!err && n < 5000) begin
            step();
            n++;
        end
        check("r16_timeout_cycles", n, PD_SETUP + 1 + PD_HOLD + TIMEOUT);
        check("r16_locked", int'(locked), 0);
        check("r16_pd", int'(div_power_down), 0);
        check("r16_idle", int'(req_ready), 1);
        check("r16_div", int'(div_divide_by), 16);
        fb_en = 1'b1;
        step();

        // pd_req during PD_HOLD of ratio 64.
        request(8'd64);
        step(); step(); step();
        check("r64_div_loaded", int'(div_divide_by), 64);
        pd_req = 1'b1;
        check("r64_ready_low", int'(req_ready), 0);
        dones = 0;
        repeat (8) begin
            step();
            dones += int'(done);
        end
        check("r64_no_done", dones, 0);
        check("r64_pd_off", int'(div_power_down), 1);
        check("r64_div_kept", int'(div_divide_by), 64);
        pd_req = 1'b0;
        wait_done("r64_resettle_done", 200);
        check("r64_locked", int'(locked), 1);
        step();

        // Request during SETTLE is dropped, not queued.
        request(8'd4);
        repeat (6) step();
        req_valid = 1'b1;
        req_div = 8'd32;
        step();
        req_valid = 1'b0;
        wait_done("r4_done", 200);
        repeat (20) step();
        check("r4_div_kept", int'(div_divide_by), 4);
        check("r4_no_pending", int'(div_power_down), 0);

        // Asynchronous reset mid-SETTLE.
        request(8'd6);
        repeat (7) step();
        rst_n = 1'b0;
        #1;
        check("mid_rst_pd", int'(div_power_down), 1);
        check("mid_rst_div", int'(div_divide_by), 2);
        check("mid_rst_locked", int'(locked), 0);
        check("mid_rst_ready", int'(req_ready), 0);
        check("mid_rst_done", int'(done), 0);
        check("mid_rst_err", int'(err), 0);
        step(); step();
        rst_n = 1'b1;
        wait_done("rst2_done", 200);
        check("rst2_locked", int'(locked), 1);
        check("rst2_div", int'(div_divide_by), 2);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/divider_ctrl.md
DIVIDER_CTRL -- requirements
Module: divider_ctrl

Interface
REQ-001 Parameter PD_SETUP_CYC, default 2: clk_in cycles div_power_down is held high before div_divide_by changes.
REQ-002 Parameter PD_HOLD_CYC, default 2: clk_in cycles div_power_down stays high after div_divide_by changes.
REQ-003 Parameter SETTLE_EDGES, default 4: synchronized rising edges of div_clk_fb required to declare lock.
REQ-004 Parameter TIMEOUT_CYC, default 4096: clk_in cycles allowed in SETTLE before fault.
REQ-005 Parameter RESET_DIV, default 8'd2: div_divide_by value after reset.
REQ-006 Port clk_in  input  1  DCO clock; the only clock.
REQ-007 Port rst_n  input  1  asynchronous active-low reset.
REQ-008 Port pd_req  input  1  EMAS register power-down request; level-sensitive.
REQ-009 Port req_valid  input  1  new divide ratio request.
REQ-010 Port req_div  input  8  requested divide ratio; sampled on acceptance.
REQ-011 Port req_ready  output  1  high only in IDLE with pd_req low.
REQ-012 Port div_power_down  output  1  to DIVIDER power_down.
REQ-013 Port div_divide_by  output  8  to DIVIDER divide_by.
REQ-014 Port div_clk_fb  input  1  DIVIDER clk_out, fed back.
REQ-015 Port locked  output  1  divider running at div_divide_by and settled.
REQ-016 Port done  output  1  one-cycle pulse on successful sequence completion.
REQ-017 Port err  output  1  one-cycle pulse on rejected request or timeout.

Function
REQ-018 div_clk_fb SHALL pass a 2-flop synchronizer; a rising edge is sync2 high with previous sync2 low.
REQ-019 States SHALL be OFF, PD_SETUP, LOAD, PD_HOLD, SETTLE, IDLE.
REQ-020 A request is accepted on a clk_in edge with req_valid and req_ready high; req_div is latched then.
REQ-021 Accepted req_div < 2: no state change, div_divide_by unchanged, err pulses next cycle, locked unchanged.
REQ-022 Accepted req_div >= 2: next state PD_SETUP, locked low, div_power_down high from the following cycle.
REQ-023 PD_SETUP lasts PD_SETUP_CYC cycles, then LOAD for exactly 1 cycle, in which div_divide_by takes the latched value.
REQ-024 PD_HOLD lasts PD_HOLD_CYC cycles, then SETTLE with div_power_down low.
REQ-025 div_divide_by SHALL change only in LOAD; div_power_down SHALL be high throughout PD_SETUP, LOAD, PD_HOLD and OFF.
REQ-026 SETTLE counts fb rising edges; edge counter and timeout counter SHALL clear on SETTLE entry.
REQ-027 On SETTLE_EDGES-th edge: done pulses 1 cycle, locked goes high, state IDLE, same cycle.
REQ-028 Timeout reached in SETTLE before SETTLE_EDGES edges: err pulses, locked stays low, state IDLE, div_power_down stays low.
REQ-029 req_valid while req_ready low SHALL be ignored, not queued.
REQ-030 pd_req high in any state SHALL force OFF next cycle: div_power_down high, locked low, counters cleared, no done/err pulse; an in-flight sequence is abandoned and a latched but unloaded ratio is discarded.
REQ-031 OFF with pd_req low SHALL go to PD_HOLD (current div_divide_by kept), then SETTLE as normal.
REQ-032 pd_req and an accepted request cannot coincide; pd_req high forces req_ready low.
REQ-033 Counters SHALL saturate-free fit their parameter width; no wrap-around is permitted.

Reset
REQ-034 rst_n low SHALL asynchronously set state OFF, div_power_down 1, div_divide_by RESET_DIV, locked 0, done 0, err 0, req_ready 0, synchronizer and counters 0.
REQ-035 After rst_n release with pd_req low, block SHALL sequence PD_HOLD -> SETTLE -> IDLE and pulse done.

Verification
REQ-036 Reset release, pd_req=0, DIVIDER divide_by 2 -> after PD_HOLD_CYC+settling of 4 fb edges, done pulse, locked=1, div_divide_by=2.
REQ-037 From IDLE, req_div=8 accepted -> power_down high 1 cycle later, divide_by=8 exactly 3 cycles after acceptance, power_down low 2 cycles later, done after 4 fb edges.
REQ-038 req_div=1 and req_div=0 -> err pulse each, div_divide_by and locked unchanged.
REQ-039 div_clk_fb tied 0 after req_div=16 -> err pulse exactly TIMEOUT_CYC cycles after SETTLE entry, locked=0, state IDLE.
REQ-040 pd_req raised during PD_HOLD of req_div=64 -> power_down stays 1, no done, divide_by=64; pd_req dropped -> re-settle, done, locked=1.
REQ-041 req_valid pulsed during SETTLE with req_div=32 -> ignored; divide_by keeps prior value; rst_n asserted mid-SETTLE -> outputs to REQ-034 values immediately.
